// File: rtl/cpu_step_ctrl_if.sv
// cpu_step_ctrl_if: pushbutton inputs and CPU step strobe/status bundle.
interface cpu_step_ctrl_if;
   logic        btn_step_n;
   logic        btn_mode_n;
   logic        cpu_en;
   logic        run_mode;
   logic [15:0] step_count;
   modport master (output btn_step_n, btn_mode_n, input cpu_en, run_mode, step_count);
   modport slave  (input btn_step_n, btn_mode_n, output cpu_en, run_mode, step_count);
endinterface

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: debounced single-step / free-run clock-enable generator for the CPU core.
module cpu_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int RUN_DIV         = 50000000
) (
   input logic              clk,
   input logic              rst,
   cpu_step_ctrl_if.slave   bus
);
   localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PW = $clog2(RUN_DIV);
   typedef enum logic {STEP, RUN} state_t;
   state_t state, state_nx;
   logic [1:0] raw, s1, s2, db, db_d, armed, settle, press;
   logic [DW-1:0] dbc [2];
   logic [PW-1:0] psc, psc_nx;
   logic tc, en, en_nx;
   logic [15:0] step_cnt;
   assign raw = {bus.btn_mode_n, bus.btn_step_n};
   // a button only arms once it is seen released after reset, so one held through reset is ignored
   assign press = armed & db_d & ~db;
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1 <= '1;
         s2 <= '1;
         db <= '1;
         db_d <= '1;
         armed <= '0;
         settle <= '0;
         for (int i = 0; i < 2; i++) dbc[i] <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         db_d <= db;
         settle <= {settle[0], 1'b1};
         armed <= armed | (s2 & {2{settle[1]}});
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == db[i]) dbc[i] <= '0;
            else if (dbc[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               db[i] <= s2[i];
               dbc[i] <= '0;
            end else dbc[i] <= dbc[i] + DW'(1);
         end
      end
   end
   always_comb begin
      tc = state == RUN && psc == PW'(RUN_DIV - 1);
      state_nx = press[1] ? (state == STEP ? RUN : STEP) : state;
      en_nx = !press[1] && (state == STEP ? press[0] : tc);
      psc_nx = (press[1] || state == STEP || tc) ? '0 : psc + PW'(1);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= STEP;
         psc <= '0;
         en <= 1'b0;
         step_cnt <= '0;
      end else begin
         state <= state_nx;
         psc <= psc_nx;
         en <= en_nx;
         step_cnt <= step_cnt + 16'(en);
      end
   end
   assign bus.cpu_en = en;
   assign bus.run_mode = state == RUN;
   assign bus.step_count = step_cnt;
endmodule
